// File: rtl/qam_pkg.sv
// qam_pkg: types and default constants shared by the QAM transmit chain
// (symbol controller, sine/cosine LUT and mixer).
package qam_pkg;

    // Bits per symbol: {sin sign, cos sign}.
    localparam int unsigned SYM_W = 2;

    // Default clk cycles per LUT sample and LUT samples per symbol.
    localparam int unsigned DEF_SAMPLE_DIV      = 4;
    localparam int unsigned DEF_SAMPLES_PER_SYM = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRIME    = 2'd1,
        RUN      = 2'd2,
        STOPPING = 2'd3
    } qam_state_e;

    // The sample timer runs only while symbols are on the air.
    function automatic logic is_running(input qam_state_e s);
        return (s == RUN) || (s == STOPPING);
    endfunction

endpackage

// File: rtl/qam_sample_timer.sv
// qam_sample_timer: prescaler plus phase counter. Emits the LUT sample
// strobe, the sample index within the symbol and the symbol boundary.
module qam_sample_timer
    import qam_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV      = DEF_SAMPLE_DIV,
    parameter int unsigned SAMPLES_PER_SYM = DEF_SAMPLES_PER_SYM,
    parameter int unsigned PHASE_W         = $clog2(SAMPLES_PER_SYM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_i,       // controller is running this cycle
    input  logic               run_next_i,  // controller will be running next cycle
    output logic               sample_en_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic               boundary_o
);

    localparam int unsigned PRE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(SAMPLE_DIV - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SAMPLES_PER_SYM - 1);

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               sample_en_q, sample_en_d;
    logic               keep;

    // Next count values; the strobe is computed from the next prescaler value so
    // that it is high exactly in the cycle whose registered count is SAMPLE_DIV-1.
    always_comb begin
        keep        = run_i && run_next_i;
        pre_d       = '0;
        phase_d     = '0;
        sample_en_d = 1'b0;
        if (keep) begin
            pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
            phase_d = sample_en_q ? phase_q + 1'b1 : phase_q;
        end
        sample_en_d = run_next_i && (pre_d == PRE_LAST);
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q       <= '0;
            phase_q     <= '0;
            sample_en_q <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            phase_q     <= phase_d;
            sample_en_q <= sample_en_d;
        end
    end

    assign sample_en_o = sample_en_q;
    assign phase_o     = phase_q;
    assign boundary_o  = sample_en_q && (phase_q == PHASE_LAST);

endmodule

// File: rtl/qam_symbol_ctrl.sv
// qam_symbol_ctrl: QAM symbol scheduler. Pulls serial bits over valid/ready,
// packs bit pairs into 2-bit sign symbols and releases them to the mixer only
// on carrier-period boundaries.
// Optional macro QAM_CTRL_UNDERRUN_CNT_EN adds the saturating underrun_cnt port.
module qam_symbol_ctrl
    import qam_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV      = DEF_SAMPLE_DIV,
    parameter int unsigned SAMPLES_PER_SYM = DEF_SAMPLES_PER_SYM,
    parameter int unsigned PHASE_W         = $clog2(SAMPLES_PER_SYM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               bit_valid,
    input  logic               bit_data,
    output logic               bit_ready,
    output logic               sample_en,
    output logic [PHASE_W-1:0] phase,
    output logic [SYM_W-1:0]   sym_out,
    output logic               sym_valid,
    output logic               busy,
    output logic               underrun
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
    ,
    output logic [7:0]         underrun_cnt
`endif
);

    qam_state_e       state_q, state_d;
    logic [SYM_W-1:0] buf_q, buf_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic             sym_valid_q, sym_valid_d;
    logic             busy_q;
    logic             underrun_q, underrun_d;
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
    logic [7:0]       ucnt_q, ucnt_d;
`endif

    logic             accept;
    logic             boundary;

    qam_sample_timer #(
        .SAMPLE_DIV      (SAMPLE_DIV),
        .SAMPLES_PER_SYM (SAMPLES_PER_SYM),
        .PHASE_W         (PHASE_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .run_i       (is_running(state_q)),
        .run_next_i  (is_running(state_d)),
        .sample_en_o (sample_en),
        .phase_o     (phase),
        .boundary_o  (boundary)
    );

    assign bit_ready = ((state_q == PRIME) || (state_q == RUN)) && (cnt_q != 2'd2);
    assign accept    = bit_valid && bit_ready;

    // Next-state logic for the controller FSM, bit buffer and symbol register.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        sym_d       = sym_q;
        sym_valid_d = sym_valid_q;
        underrun_d  = underrun_q;
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
        ucnt_d      = ucnt_q;
`endif
        // An accepted bit always appends: a full buffer blocks acceptance, so
        // this never collides with a buffer clear, and on an underrun boundary
        // the partial bits are kept and extended.
        if (accept) begin
            buf_d = {buf_q[0], bit_data};
            cnt_d = cnt_q + 2'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = PRIME;
                    buf_d      = '0;
                    cnt_d      = '0;
                    underrun_d = 1'b0;
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
                    ucnt_d     = '0;
`endif
                end
            end
            PRIME: begin
                if (cnt_q == 2'd2) begin
                    state_d     = RUN;
                    sym_d       = buf_q;
                    sym_valid_d = 1'b1;
                    buf_d       = '0;
                    cnt_d       = '0;
                end
            end
            RUN: begin
                if (boundary) begin
                    if (cnt_q == 2'd2) begin
                        sym_d = buf_q;
                        buf_d = '0;
                        cnt_d = '0;
                    end else begin
                        underrun_d = 1'b1;
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
                        if (ucnt_q != '1) ucnt_d = ucnt_q + 8'd1;
`endif
                    end
                end
                if (stop) state_d = STOPPING;
            end
            STOPPING: begin
                if (boundary) begin
                    state_d     = IDLE;
                    sym_valid_d = 1'b0;
                    sym_d       = '0;
                    buf_d       = '0;
                    cnt_d       = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
            ucnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            busy_q      <= (state_d != IDLE);
            underrun_q  <= underrun_d;
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
            ucnt_q      <= ucnt_d;
`endif
        end
    end

    assign sym_out   = sym_q;
    assign sym_valid = sym_valid_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
    assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_qam_symbol_ctrl.sv
// tb_qam_symbol_ctrl: two instances (default timing and SAMPLE_DIV=1,
// SAMPLES_PER_SYM=2) checked every cycle against a cycle-count model, plus
// directed literal checks.
`timescale 1ns/1ps
module tb_qam_symbol_ctrl;

    localparam int DIV0 = 4, SPS0 = 32;
    localparam int DIV1 = 1, SPS1 = 2;
    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_STOP = 3;

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, stop = 1'b0, bit_valid = 1'b0, bit_data = 1'b0;
    always #5 clk = ~clk;

    logic       rdy0, se0, sv0, busy0, und0;
    logic [4:0] ph0;
    logic [1:0] sym0;
    logic       rdy1, se1, sv1, busy1, und1;
    logic [0:0] ph1;
    logic [1:0] sym1;
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
    logic [7:0] uc0, uc1;
`endif

    qam_symbol_ctrl #(.SAMPLE_DIV(DIV0), .SAMPLES_PER_SYM(SPS0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(rdy0),
        .sample_en(se0), .phase(ph0), .sym_out(sym0), .sym_valid(sv0),
        .busy(busy0), .underrun(und0)
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
        , .underrun_cnt(uc0)
`endif
    );

    qam_symbol_ctrl #(.SAMPLE_DIV(DIV1), .SAMPLES_PER_SYM(SPS1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(rdy1),
        .sample_en(se1), .phase(ph1), .sym_out(sym1), .sym_valid(sv1),
        .busy(busy1), .underrun(und1)
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
        , .underrun_cnt(uc1)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timing is derived from t = clk cycles since RUN entry.
    int         m_st[2], m_cnt[2], m_t[2], m_ucnt[2];
    logic [1:0] m_buf[2], m_sym[2];
    logic       m_valid[2], m_und[2];

    function automatic int div_of(input int k);
        return (k == 0) ? DIV0 : DIV1;
    endfunction
    function automatic int sps_of(input int k);
        return (k == 0) ? SPS0 : SPS1;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_st[k] = M_IDLE; m_cnt[k] = 0; m_t[k] = 0; m_ucnt[k] = 0;
            m_buf[k] = 2'b00; m_sym[k] = 2'b00; m_valid[k] = 1'b0; m_und[k] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int   per;
            logic acc, bnd, running;
            per     = div_of(k) * sps_of(k);
            acc     = bit_valid && (m_st[k] == M_PRIME || m_st[k] == M_RUN) && (m_cnt[k] < 2);
            running = (m_st[k] == M_RUN) || (m_st[k] == M_STOP);
            bnd     = running && ((m_t[k] % per) == per - 1);
            if (!rst) begin
                m_st[k] = M_IDLE; m_cnt[k] = 0; m_t[k] = 0; m_ucnt[k] = 0;
                m_buf[k] = 2'b00; m_sym[k] = 2'b00; m_valid[k] = 1'b0; m_und[k] = 1'b0;
            end else begin
                case (m_st[k])
                    M_IDLE: if (start) begin
                        m_st[k] = M_PRIME; m_cnt[k] = 0; m_und[k] = 1'b0; m_ucnt[k] = 0;
                    end
                    M_PRIME: begin
                        if (m_cnt[k] == 2) begin
                            m_sym[k] = m_buf[k]; m_valid[k] = 1'b1; m_cnt[k] = 0;
                            m_st[k] = M_RUN; m_t[k] = 0;
                        end else if (acc) begin
                            m_buf[k][1 - m_cnt[k]] = bit_data; m_cnt[k]++;
                        end
                    end
                    M_RUN: begin
                        if (bnd) begin
                            if (m_cnt[k] == 2) begin
                                m_sym[k] = m_buf[k]; m_cnt[k] = 0;
                            end else begin
                                m_und[k] = 1'b1;
                                if (m_ucnt[k] < 255) m_ucnt[k]++;
                            end
                        end
                        if (acc) begin
                            m_buf[k][1 - m_cnt[k]] = bit_data; m_cnt[k]++;
                        end
                        if (stop) m_st[k] = M_STOP;
                        m_t[k]++;
                    end
                    default: begin
                        if (bnd) begin
                            m_st[k] = M_IDLE; m_valid[k] = 1'b0; m_sym[k] = 2'b00;
                            m_cnt[k] = 0; m_t[k] = 0;
                        end else begin
                            m_t[k]++;
                        end
                    end
                endcase
            end
        end
    end

    task automatic check_dut(input int k, input logic rdy, input logic se, input int ph,
                             input logic [1:0] sym, input logic sv, input logic bz,
                             input logic und, input int uc);
        logic running;
        int   dv, sp;
        dv      = div_of(k);
        sp      = sps_of(k);
        running = (m_st[k] == M_RUN) || (m_st[k] == M_STOP);
        cmp($sformatf("dut%0d.bit_ready", k), 32'(rdy),
            32'((m_st[k] == M_PRIME || m_st[k] == M_RUN) && m_cnt[k] < 2));
        cmp($sformatf("dut%0d.sample_en", k), 32'(se), 32'(running && (m_t[k] % dv) == dv - 1));
        cmp($sformatf("dut%0d.phase", k), ph, running ? (m_t[k] / dv) % sp : 0);
        cmp($sformatf("dut%0d.sym_out", k), 32'(sym), 32'(m_sym[k]));
        cmp($sformatf("dut%0d.sym_valid", k), 32'(sv), 32'(m_valid[k]));
        cmp($sformatf("dut%0d.busy", k), 32'(bz), 32'(m_st[k] != M_IDLE));
        cmp($sformatf("dut%0d.underrun", k), 32'(und), 32'(m_und[k]));
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
        cmp($sformatf("dut%0d.underrun_cnt", k), uc, m_ucnt[k]);
`else
        if (uc != 0) cmp($sformatf("dut%0d.underrun_cnt_tie", k), uc, 0);
`endif
    endtask

    // Compare process: every negedge, both instances against the model.
    always @(negedge clk) begin
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
        check_dut(0, rdy0, se0, int'(ph0), sym0, sv0, busy0, und0, int'(uc0));
        check_dut(1, rdy1, se1, int'(ph1), sym1, sv1, busy1, und1, int'(uc1));
`else
        check_dut(0, rdy0, se0, int'(ph0), sym0, sv0, busy0, und0, 0);
        check_dut(1, rdy1, se1, int'(ph1), sym1, sv1, busy1, und1, 0);
`endif
    end

    // ---------------- stimulus ----------------
    logic [0:15] pat_v;
    int          bidx = 0;

    // Advance one clock; the bit source steps when dut0 accepted a bit.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            logic a;
            a = bit_valid && rdy0;
            @(posedge clk);
            if (a && rst) bidx = bidx + 1;
            #1;
            bit_data = pat_v[bidx % 16];
        end
    endtask

    initial begin
        int n;
        pat_v    = 16'b1011_0100_1110_0011;
        bit_data = pat_v[0];
        rst      = 1'b0;
        tick(3);
        cmp("lit_rst_busy", 32'(busy0), 0);
        cmp("lit_rst_sym", 32'(sym0), 0);
        cmp("lit_rst_ready", 32'(rdy0), 0);

        rst = 1'b1;
        tick(1);
        start = 1'b1; bit_valid = 1'b1;
        tick(1);
        start = 1'b0;
        cmp("lit_busy_after_start", 32'(busy0), 1);
        n = 0;
        while (!sv0 && n < 20) begin tick(1); n++; end
        cmp("lit_run_entry_latency", n, 3);
        cmp("lit_first_sym", 32'(sym0), 32'h2);

        tick(127);
        cmp("lit_sym_before_bnd", 32'(sym0), 32'h2);
        cmp("lit_phase_31", 32'(ph0), 31);
        cmp("lit_se_at_31", 32'(se0), 1);
        tick(1);
        cmp("lit_second_sym", 32'(sym0), 32'h3);
        cmp("lit_phase_wrap", 32'(ph0), 0);

        bit_valid = 1'b0;
        tick(127);
        cmp("lit_no_underrun_yet", 32'(und0), 0);
        tick(1);
        cmp("lit_underrun_set", 32'(und0), 1);
        cmp("lit_underrun_hold_sym", 32'(sym0), 32'h3);
`ifdef QAM_CTRL_UNDERRUN_CNT_EN
        cmp("lit_underrun_cnt", 32'(uc0), 1);
`endif

        bit_valid = 1'b1;
        tick(128);
        cmp("lit_third_sym", 32'(sym0), 32'h1);
        cmp("lit_underrun_sticky", 32'(und0), 1);

        n = 0;
        while (ph0 != 5 && n < 100) begin tick(1); n++; end
        cmp("lit_reach_phase5", 32'(ph0), 5);
        stop = 1'b1; start = 1'b1;
        tick(1);
        stop = 1'b0; start = 1'b0;
        cmp("lit_stopping_busy", 32'(busy0), 1);
        cmp("lit_stopping_sym", 32'(sym0), 32'h1);
        n = 0;
        while (busy0 && n < 200) begin tick(1); n++; end
        cmp("lit_stop_latency", n, 107);
        cmp("lit_idle_sym_valid", 32'(sv0), 0);
        cmp("lit_idle_sym", 32'(sym0), 0);
        cmp("lit_idle_ready", 32'(rdy0), 0);
        cmp("lit_idle_underrun_kept", 32'(und0), 1);

        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
        cmp("lit_stop_in_idle", 32'(busy0), 0);
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        cmp("lit_start_stop_same", 32'(busy0), 1);
        cmp("lit_underrun_cleared", 32'(und0), 0);

        n = 0;
        while (!sv1 && n < 20) begin tick(1); n++; end
        for (int i = 0; i < 4; i++) begin
            cmp("lit_fast_se_high", 32'(se1), 1);
            tick(1);
        end

        tick(50);
        rst = 1'b0;
        tick(1);
        cmp("lit_midrun_rst_busy", 32'(busy0), 0);
        cmp("lit_midrun_rst_se", 32'(se0), 0);
        cmp("lit_midrun_rst_phase", 32'(ph0), 0);
        cmp("lit_midrun_rst_valid", 32'(sv0), 0);
        rst = 1'b1;
        tick(2);
        cmp("lit_after_rst_se", 32'(se0), 0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
